// File: rtl/qic_fmt_pkg.sv
// Shared types for the QIC block framer: header codes, block classes, FSM states, FIFO entry.
package qic_fmt_pkg;

  localparam logic [7:0] HDR_DATA      = 8'h00;
  localparam logic [7:0] HDR_FILE_MARK = 8'h1F;
  localparam logic [7:0] HDR_EOD       = 8'h0F;
  localparam logic [7:0] HDR_BAD       = 8'hFF;

  typedef enum logic [1:0] {
    BT_DATA      = 2'd0,
    BT_FILE_MARK = 2'd1,
    BT_EOD       = 2'd2,
    BT_BAD       = 2'd3
  } block_type_e;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_HEADER = 3'd2,
    ST_DATA   = 3'd3,
    ST_ECC    = 3'd4
  } state_e;

  typedef struct packed {
    logic       is_header;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  // Map a header byte onto its block class; anything unknown counts as bad.
  function automatic block_type_e classify_header(input logic [7:0] hdr);
    block_type_e bt;
    case (hdr)
      HDR_DATA:      bt = BT_DATA;
      HDR_FILE_MARK: bt = BT_FILE_MARK;
      HDR_EOD:       bt = BT_EOD;
      HDR_BAD:       bt = BT_BAD;
      default:       bt = BT_BAD;
    endcase
    return bt;
  endfunction

  // Extract the 8 data cells (second cell of each clock/data pair), MSB first.
  function automatic logic [7:0] mfm_decode(input logic [15:0] cells);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = cells[2*i];
    end
    return b;
  endfunction

endpackage

// File: rtl/qic_byte_fifo.sv
// Output byte FIFO with tags; simultaneous push/pop allowed at any level, flush empties it.
module qic_byte_fifo
  import qic_fmt_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  fifo_entry_t            push_entry,
  input  logic                   pop_ready,
  output fifo_entry_t            head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  fifo_entry_t      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_fire;
  logic             push_fire;

  // Handshake qualification; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    full      = (level == LW'(DEPTH));
    pop_fire  = pop_ready & (level != '0);
    push_fire = push & (~full | pop_fire);
    drop_c    = push & full & ~pop_fire & ~flush;
    valid     = (level != '0);
    head      = mem[rd_ptr];
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qic_block_framer.sv
// QIC tape block framer: sync hunt, MFM byte decode, block/segment tracking, byte stream out.
module qic_block_framer
  import qic_fmt_pkg::*;
#(
  parameter int unsigned DATA_BYTES     = 512,
  parameter int unsigned ECC_BYTES      = 3,
  parameter int unsigned BLOCKS_PER_SEG = 32,
  parameter logic [15:0] SYNC_WORD      = 16'h4489,
  parameter int unsigned SYNC_COUNT     = 2,
  parameter int unsigned GAP_CELLS      = 8192,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              streaming,
  input  logic                              mfm_data,
  input  logic                              mfm_clock,
  input  logic                              dpll_locked,
  output logic [7:0]                        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_is_header,
  output logic                              out_last,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [1:0]                        block_type,
  output logic [$clog2(BLOCKS_PER_SEG)-1:0] block_in_segment,
  output logic [15:0]                       segment_count,
  output logic                              block_start,
  output logic                              block_complete,
  output logic                              segment_start,
  output logic                              segment_complete,
  output logic                              file_mark_detect,
  output logic                              eod_detect,
  output logic                              sync_lost,
  output logic                              overrun_error,
  output logic                              gap_timeout,
  output logic [15:0]                       error_count
);

  localparam int unsigned BIS_W  = $clog2(BLOCKS_PER_SEG);
  localparam int unsigned BC_MAX = (DATA_BYTES > ECC_BYTES) ? DATA_BYTES : ECC_BYTES;
  localparam int unsigned BC_W   = $clog2(BC_MAX);
  localparam int unsigned GAP_W  = $clog2(GAP_CELLS);

  localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BYTES - 1);
  localparam logic [BC_W-1:0]  ECC_LAST  = BC_W'(ECC_BYTES - 1);
  localparam logic [BIS_W-1:0] BIS_LAST  = BIS_W'(BLOCKS_PER_SEG - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CELLS - 1);
  localparam logic [2:0]       SYNC_LAST = 3'(SYNC_COUNT - 1);

  state_e           state;
  logic             mfm_clock_q;
  logic [15:0]      shift_q;
  logic [3:0]       cell_cnt;
  logic [BC_W-1:0]  byte_cnt;
  logic [2:0]       sync_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             active_c;
  logic             cell_ev_c;
  logic [15:0]      shift_nxt_c;
  logic [7:0]       byte_c;
  logic             byte_done_c;
  logic             push_c;
  fifo_entry_t      entry_c;
  logic             lock_lost_c;
  logic             gap_hit_c;
  logic             drop_c;
  logic [1:0]       err_inc_c;
  logic [16:0]      err_sum_c;
  fifo_entry_t      head;

  // Cell events, byte assembly and error-event qualification.
  always_comb begin
    active_c          = enable & streaming;
    cell_ev_c         = active_c & dpll_locked & mfm_clock & ~mfm_clock_q;
    shift_nxt_c       = {shift_q[14:0], mfm_data};
    byte_c            = mfm_decode(shift_nxt_c);
    byte_done_c       = cell_ev_c & (cell_cnt == 4'hF);
    push_c            = byte_done_c & ((state == ST_HEADER) | (state == ST_DATA));
    entry_c.data      = byte_c;
    entry_c.is_header = (state == ST_HEADER);
    entry_c.last      = (state == ST_DATA) & (byte_cnt == DATA_LAST);
    lock_lost_c       = active_c & ~dpll_locked &
                        ((state == ST_HEADER) | (state == ST_DATA) | (state == ST_ECC));
    gap_hit_c         = cell_ev_c & ((state == ST_HUNT) | (state == ST_SYNC)) &
                        (block_in_segment != '0) & (gap_cnt == GAP_LAST);
    err_inc_c         = 2'(lock_lost_c) + 2'(drop_c) + 2'(gap_hit_c);
    err_sum_c         = 17'(error_count) + 17'(err_inc_c);
  end

  // Registered mfm_clock for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mfm_clock_q <= 1'b0;
    else          mfm_clock_q <= mfm_clock;
  end

  // Framing FSM, block/segment tracking, gap timer and event pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_HUNT;
      shift_q          <= '0;
      cell_cnt         <= '0;
      byte_cnt         <= '0;
      sync_cnt         <= '0;
      gap_cnt          <= '0;
      block_type       <= '0;
      block_in_segment <= '0;
      segment_count    <= '0;
      block_start      <= 1'b0;
      block_complete   <= 1'b0;
      segment_start    <= 1'b0;
      segment_complete <= 1'b0;
      file_mark_detect <= 1'b0;
      eod_detect       <= 1'b0;
      sync_lost        <= 1'b0;
      overrun_error    <= 1'b0;
      gap_timeout      <= 1'b0;
    end else begin
      block_start      <= 1'b0;
      block_complete   <= 1'b0;
      segment_start    <= 1'b0;
      segment_complete <= 1'b0;
      file_mark_detect <= 1'b0;
      eod_detect       <= 1'b0;
      sync_lost        <= lock_lost_c;
      overrun_error    <= drop_c;
      gap_timeout      <= gap_hit_c;

      if (!active_c) begin
        state    <= ST_HUNT;
        shift_q  <= '0;
        cell_cnt <= '0;
        byte_cnt <= '0;
        sync_cnt <= '0;
        gap_cnt  <= '0;
      end else if (lock_lost_c) begin
        state    <= ST_HUNT;
        cell_cnt <= '0;
        byte_cnt <= '0;
        sync_cnt <= '0;
      end else if (cell_ev_c) begin
        shift_q <= shift_nxt_c;

        if (((state == ST_HUNT) || (state == ST_SYNC)) && (block_in_segment != '0)) begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt          <= '0;
            block_in_segment <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        case (state)
          ST_HUNT: begin
            if (shift_nxt_c == SYNC_WORD) begin
              cell_cnt <= '0;
              if (SYNC_COUNT == 1) begin
                state   <= ST_HEADER;
                gap_cnt <= '0;
              end else begin
                state    <= ST_SYNC;
                sync_cnt <= 3'd1;
              end
            end
          end
          ST_SYNC: begin
            cell_cnt <= cell_cnt + 4'd1;
            if (cell_cnt == 4'hF) begin
              if (shift_nxt_c != SYNC_WORD) begin
                state    <= ST_HUNT;
                sync_cnt <= '0;
              end else if (sync_cnt == SYNC_LAST) begin
                state    <= ST_HEADER;
                sync_cnt <= '0;
                gap_cnt  <= '0;
              end else begin
                sync_cnt <= sync_cnt + 3'd1;
              end
            end
          end
          ST_HEADER: begin
            cell_cnt <= cell_cnt + 4'd1;
            if (cell_cnt == 4'hF) begin
              block_type       <= classify_header(byte_c);
              block_start      <= 1'b1;
              segment_start    <= (block_in_segment == '0);
              file_mark_detect <= (byte_c == HDR_FILE_MARK);
              eod_detect       <= (byte_c == HDR_EOD);
              byte_cnt         <= '0;
              state            <= ST_DATA;
            end
          end
          ST_DATA: begin
            cell_cnt <= cell_cnt + 4'd1;
            if (cell_cnt == 4'hF) begin
              if (byte_cnt == DATA_LAST) begin
                byte_cnt <= '0;
                state    <= ST_ECC;
              end else begin
                byte_cnt <= byte_cnt + BC_W'(1);
              end
            end
          end
          ST_ECC: begin
            cell_cnt <= cell_cnt + 4'd1;
            if (cell_cnt == 4'hF) begin
              if (byte_cnt == ECC_LAST) begin
                byte_cnt       <= '0;
                block_complete <= 1'b1;
                state          <= ST_HUNT;
                if (block_in_segment == BIS_LAST) begin
                  block_in_segment <= '0;
                  segment_complete <= 1'b1;
                  segment_count    <= segment_count + 16'd1;
                end else begin
                  block_in_segment <= block_in_segment + BIS_W'(1);
                end
              end else begin
                byte_cnt <= byte_cnt + BC_W'(1);
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  // Saturating error event counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          error_count <= '0;
    else if (err_sum_c[16]) error_count <= 16'hFFFF;
    else                   error_count <= err_sum_c[15:0];
  end

  // Output byte FIFO; disabling the framer flushes it.
  qic_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (~active_c),
    .push      (push_c),
    .push_entry(entry_c),
    .pop_ready (out_ready),
    .head      (head),
    .valid     (out_valid),
    .level     (fifo_level),
    .drop_c    (drop_c)
  );

  assign out_data      = head.data;
  assign out_is_header = head.is_header;
  assign out_last      = head.last;

endmodule
